// File: rtl/boton_acondicionador.sv
// -----------------------------------------------------------------------------
// boton_acondicionador
//
// Conditions the raw push-button pins feeding controlprincipal. Each channel is
// polarity-normalised, passed through a 2-FF synchroniser and then debounced by
// a small FSM (IDLE -> ARM -> ON -> DISARM). Downstream logic consumes the
// clean level and the single-cycle press / release / long-press pulses.
// Channels are fully independent.
//
// Optional feature macro: BOTON_LONGPRESS_EN
//   defined   : hold counter, long-fired flag and btn_long pulse are built.
//   undefined : btn_long is tied to 0; level/press/release are unchanged.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst_n        in   synchronous active-low reset
//   btn_raw      in   [N_BTN] raw asynchronous button pins
//   btn_level    out  [N_BTN] debounced level, 1 = pressed
//   btn_press    out  [N_BTN] 1-cycle pulse on debounced press
//   btn_release  out  [N_BTN] 1-cycle pulse on debounced release
//   btn_long     out  [N_BTN] 1-cycle pulse once per press after LONG_CYC hold
// -----------------------------------------------------------------------------
module boton_acondicionador #(
  parameter int N_BTN       = 8,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int DEB_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DW      = $clog2(DEB_CYC + 1);
`ifdef BOTON_LONGPRESS_EN
  localparam int LONG_CYC = (CLK_HZ / 1000) * LONG_MS;
  localparam int HW       = $clog2(LONG_CYC + 1);
`endif

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_MS <= 0) begin : g_chk_debounce
    $error("boton_acondicionador: DEBOUNCE_MS must be greater than 0");
  end
  if (LONG_MS <= 0) begin : g_chk_long
    $error("boton_acondicionador: LONG_MS must be greater than 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ON,
    DISARM
  } state_t;

  // Input stage: normalise to 1 = pressed, then synchronise.
  logic [N_BTN-1:0] pressed_raw;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] s;

  assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the 2-FF chain into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= pressed_raw;
      s     <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t        state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic          press_nxt, release_nxt;
    logic          level_q, press_q, release_q;

    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      unique case (state)
        IDLE: begin
          if (s[i]) begin
            state_nxt = ARM;
            cnt_nxt   = DW'(1);
          end
        end
        ARM: begin
          if (!s[i]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DW'(DEB_CYC)) begin
            state_nxt = ON;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ON: begin
          if (!s[i]) begin
            state_nxt = DISARM;
            cnt_nxt   = DW'(1);
          end
        end
        DISARM: begin
          if (s[i]) begin
            // Bounce during release: back to ON, hold time keeps running.
            state_nxt = ON;
            cnt_nxt   = '0;
          end else if (cnt == DW'(DEB_CYC)) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level_q   <= (state_nxt == ON) || (state_nxt == DISARM);
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef BOTON_LONGPRESS_EN
    logic [HW-1:0] hold, hold_nxt;
    logic          fired, fired_nxt, long_nxt, long_q;

    // Hold time counts only in ON (paused during a DISARM excursion) and
    // saturates; the fired flag limits btn_long to one pulse per press.
    always_comb begin
      hold_nxt  = hold;
      fired_nxt = fired;
      long_nxt  = 1'b0;
      if (press_nxt || release_nxt) begin
        hold_nxt = '0;
        if (release_nxt) begin
          fired_nxt = 1'b0;
        end
      end else if (state == ON) begin
        if (hold != HW'(LONG_CYC)) begin
          hold_nxt = hold + 1'b1;
        end
        if ((hold_nxt == HW'(LONG_CYC)) && !fired) begin
          long_nxt  = 1'b1;
          fired_nxt = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold   <= '0;
        fired  <= 1'b0;
        long_q <= 1'b0;
      end else begin
        hold   <= hold_nxt;
        fired  <= fired_nxt;
        long_q <= long_nxt;
      end
    end

    assign btn_long[i] = long_q;
`endif
  end

`ifndef BOTON_LONGPRESS_EN
  assign btn_long = '0;
`endif

endmodule
